// File: rtl/multicycle_control_fsm_pkg.sv
// Shared constants for the multicycle RISC-V control path: opcodes, state
// encodings, ALUOp codes, datapath mux selects and the control output bundle.
package multicycle_control_fsm_pkg;

    localparam int unsigned ALUOP_W = 6;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned SEL_W   = 2;

    // Major opcodes (instruction[6:0])
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

    // Control states; 13..15 are unused encodings
    typedef enum logic [STATE_W-1:0] {
        S_INIT     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_ALUWB    = 4'd8,
        S_EXECI    = 4'd9,
        S_JAL      = 4'd10,
        S_BEQ      = 4'd11,
        S_HALT     = 4'd12
    } state_e;

    // ALUOp codes consumed by the ALU control decoder
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = ALUOP_W'(2);

    // ResultSrc selects
    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEMDATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA selects
    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    // ALUSrcB selects
    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    // Full set of datapath controls produced each cycle
    typedef struct packed {
        logic               pc_write;
        logic               branch;
        logic               adr_src;
        logic               mem_write;
        logic               ir_write;
        logic               reg_write;
        logic [SEL_W-1:0]   result_src;
        logic [SEL_W-1:0]   alu_src_a;
        logic [SEL_W-1:0]   alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic               illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Opcode/handshake inputs and datapath control outputs of the main control unit.
interface multicycle_control_fsm_if;
    import multicycle_control_fsm_pkg::*;

    logic [OPC_W-1:0]   iOpcode;
    logic               iMemReady;
    logic               oPCWrite;
    logic               oBranch;
    logic               oAdrSrc;
    logic               oMemWrite;
    logic               oIRWrite;
    logic               oRegWrite;
    logic [SEL_W-1:0]   oResultSrc;
    logic [SEL_W-1:0]   oALUSrcA;
    logic [SEL_W-1:0]   oALUSrcB;
    logic [ALUOP_W-1:0] oALUOp;
    logic [STATE_W-1:0] oState;
    logic               oIllegal;

    // Datapath side: supplies opcode and memory handshake, consumes controls
    modport master (
        output iOpcode, iMemReady,
        input  oPCWrite, oBranch, oAdrSrc, oMemWrite, oIRWrite, oRegWrite,
               oResultSrc, oALUSrcA, oALUSrcB, oALUOp, oState, oIllegal
    );

    // Control unit side
    modport slave (
        input  iOpcode, iMemReady,
        output oPCWrite, oBranch, oAdrSrc, oMemWrite, oIRWrite, oRegWrite,
               oResultSrc, oALUSrcA, oALUSrcB, oALUOp, oState, oIllegal
    );

endinterface

// File: rtl/multicycle_ctrl_out_decode.sv
// Combinational Moore decode of control state into datapath controls.
// FETCH is the one exception: IR and PC loads follow the memory ready strobe.
// ILLEGAL_TRAP_EN: when defined, the HALT state raises the illegal flag.
module multicycle_ctrl_out_decode
    import multicycle_control_fsm_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    // Per-state control map; anything not set stays 0
    always_comb begin
        ctrl_o = CTRL_IDLE;
        case (state_i)
            S_FETCH: begin
                ctrl_o.adr_src    = 1'b0;
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.result_src = RES_ALURESULT;
                ctrl_o.ir_write   = mem_ready_i;
                ctrl_o.pc_write   = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a = SRCA_OLDPC;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl_o.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.result_src = RES_MEMDATA;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.adr_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_EXECR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_RS2;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_JAL: begin
                ctrl_o.alu_src_a  = SRCA_OLDPC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.pc_write   = 1'b1;
            end
            S_ALUWB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_write  = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.alu_src_a  = SRCA_RS1;
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.alu_op     = ALUOP_SUB;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.branch     = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_HALT: begin
                ctrl_o.illegal = 1'b1;
            end
`endif
            default: begin
                ctrl_o = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control unit of the multicycle RISC-V datapath: sequences
// fetch/decode/execute/memory/writeback and stalls on the memory handshake.
// ILLEGAL_TRAP_EN: when defined, an illegal opcode traps into HALT until
// reset; otherwise it is retired as a no-op back to FETCH.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
(
    input  logic                     iCLK,
    input  logic                     iRST,
    multicycle_control_fsm_if.slave  bus
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    // State register; reset forces INIT without waiting for a clock edge
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing from opcode and memory ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:     state_d = S_FETCH;
            S_FETCH:    state_d = bus.iMemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.iOpcode)
                    OPC_LOAD,
                    OPC_STORE:  state_d = S_MEMADR;
                    OPC_OP:     state_d = S_EXECR;
                    OPC_OPIMM:  state_d = S_EXECI;
                    OPC_JAL:    state_d = S_JAL;
                    OPC_BRANCH: state_d = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
                    default:    state_d = S_HALT;
`else
                    default:    state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (bus.iOpcode == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = bus.iMemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = bus.iMemReady ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_HALT:     state_d = S_HALT;
`else
            S_HALT:     state_d = S_INIT;
`endif
            default:    state_d = S_INIT;
        endcase
    end

    multicycle_ctrl_out_decode u_out_decode (
        .state_i     (state_q),
        .mem_ready_i (bus.iMemReady),
        .ctrl_o      (ctrl)
    );

    // Drive the control bus from the decoded bundle
    assign bus.oPCWrite   = ctrl.pc_write;
    assign bus.oBranch    = ctrl.branch;
    assign bus.oAdrSrc    = ctrl.adr_src;
    assign bus.oMemWrite  = ctrl.mem_write;
    assign bus.oIRWrite   = ctrl.ir_write;
    assign bus.oRegWrite  = ctrl.reg_write;
    assign bus.oResultSrc = ctrl.result_src;
    assign bus.oALUSrcA   = ctrl.alu_src_a;
    assign bus.oALUSrcB   = ctrl.alu_src_b;
    assign bus.oALUOp     = ctrl.alu_op;
    assign bus.oState     = state_q;
    assign bus.oIllegal   = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-cycle vector table through a
// scoreboard queue, plus hand-written reset and illegal-opcode sequences.
// Expectations follow ILLEGAL_TRAP_EN when it is defined for the build.
module tb_multicycle_control_fsm;
    import multicycle_control_fsm_pkg::*;

    typedef logic [22:0] outv_t;
    typedef struct {
        logic [6:0] opc;
        logic       rdy;
        outv_t      exp;
    } vec_t;

    logic  iCLK;
    logic  iRST;
    outv_t dut_v;
    vec_t  vecs[$];
    outv_t exp_q[$];
    string name_q[$];
    int    checks;
    int    errors;

    localparam logic [6:0] OPC_ILL = 7'b1111111;

    multicycle_control_fsm_if bus_if();

    multicycle_control_fsm dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus_if)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    assign dut_v = {bus_if.oState, bus_if.oPCWrite, bus_if.oBranch, bus_if.oAdrSrc,
                    bus_if.oMemWrite, bus_if.oIRWrite, bus_if.oRegWrite,
                    bus_if.oResultSrc, bus_if.oALUSrcA, bus_if.oALUSrcB,
                    bus_if.oALUOp, bus_if.oIllegal};

    function automatic outv_t mk(input logic [3:0] st, input logic pcw, input logic br,
                                 input logic adr, input logic mw, input logic irw,
                                 input logic rw, input logic [1:0] rs, input logic [1:0] sa,
                                 input logic [1:0] sb, input logic [5:0] op, input logic ill);
        return {st, pcw, br, adr, mw, irw, rw, rs, sa, sb, op, ill};
    endfunction

    // Expected control vectors, one per state, written out from the state table
    function automatic outv_t e_init();     return mk(4'd0,  0,0,0,0,0,0, 2'b00,2'b00,2'b00, 6'd0, 0); endfunction
    function automatic outv_t e_fetch(input logic r);
                                            return mk(4'd1,  r,0,0,0,r,0, 2'b10,2'b00,2'b10, 6'd0, 0); endfunction
    function automatic outv_t e_decode();   return mk(4'd2,  0,0,0,0,0,0, 2'b00,2'b01,2'b01, 6'd0, 0); endfunction
    function automatic outv_t e_memadr();   return mk(4'd3,  0,0,0,0,0,0, 2'b00,2'b10,2'b01, 6'd0, 0); endfunction
    function automatic outv_t e_memread();  return mk(4'd4,  0,0,1,0,0,0, 2'b00,2'b00,2'b00, 6'd0, 0); endfunction
    function automatic outv_t e_memwb();    return mk(4'd5,  0,0,0,0,0,1, 2'b01,2'b00,2'b00, 6'd0, 0); endfunction
    function automatic outv_t e_memwrite(); return mk(4'd6,  0,0,1,1,0,0, 2'b00,2'b00,2'b00, 6'd0, 0); endfunction
    function automatic outv_t e_execr();    return mk(4'd7,  0,0,0,0,0,0, 2'b00,2'b10,2'b00, 6'd2, 0); endfunction
    function automatic outv_t e_aluwb();    return mk(4'd8,  0,0,0,0,0,1, 2'b00,2'b00,2'b00, 6'd0, 0); endfunction
    function automatic outv_t e_execi();    return mk(4'd9,  0,0,0,0,0,0, 2'b00,2'b10,2'b01, 6'd0, 0); endfunction
    function automatic outv_t e_jal();      return mk(4'd10, 1,0,0,0,0,0, 2'b00,2'b01,2'b10, 6'd0, 0); endfunction
    function automatic outv_t e_beq();      return mk(4'd11, 0,1,0,0,0,0, 2'b00,2'b10,2'b00, 6'd1, 0); endfunction
    function automatic outv_t e_halt();     return mk(4'd12, 0,0,0,0,0,0, 2'b00,2'b00,2'b00, 6'd0, 1); endfunction

    function automatic void add(input logic [6:0] opc, input logic rdy, input outv_t exp);
        vec_t v;
        v.opc = opc;
        v.rdy = rdy;
        v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input outv_t exp);
        checks++;
        if (dut_v !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                     nm, dut_v[22:19], dut_v, exp[22:19], exp);
        end
    endtask

    task automatic pop_check();
        outv_t e;
        string n;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, e);
        end
    endtask

    // One cycle: drive inputs after the edge, queue the expectation, compare mid-cycle
    task automatic drive(input logic [6:0] opc, input logic rdy, input outv_t exp, input string nm);
        @(posedge iCLK);
        #1;
        bus_if.iOpcode   = opc;
        bus_if.iMemReady = rdy;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge iCLK);
        pop_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        iRST = 1'b1;
        bus_if.iOpcode   = 7'd0;
        bus_if.iMemReady = 1'b0;

        // R-type, no waits: 1,2,7,8
        add(OPC_OP, 1, e_fetch(1)); add(OPC_OP, 1, e_decode());
        add(OPC_OP, 1, e_execr());  add(OPC_OP, 1, e_aluwb());
        // lw with two wait cycles in MEMREAD: 1,2,3,4,4,4,5
        add(OPC_LOAD, 1, e_fetch(1)); add(OPC_LOAD, 1, e_decode());
        add(OPC_LOAD, 1, e_memadr());
        add(OPC_LOAD, 0, e_memread()); add(OPC_LOAD, 0, e_memread());
        add(OPC_LOAD, 1, e_memread()); add(OPC_LOAD, 1, e_memwb());
        // sw with one wait in MEMWRITE
        add(OPC_STORE, 1, e_fetch(1)); add(OPC_STORE, 1, e_decode());
        add(OPC_STORE, 0, e_memadr());
        add(OPC_STORE, 0, e_memwrite()); add(OPC_STORE, 1, e_memwrite());
        // beq: 3 cycles
        add(OPC_BRANCH, 1, e_fetch(1)); add(OPC_BRANCH, 1, e_decode());
        add(OPC_BRANCH, 1, e_beq());
        // OPIMM
        add(OPC_OPIMM, 1, e_fetch(1)); add(OPC_OPIMM, 1, e_decode());
        add(OPC_OPIMM, 0, e_execi());  add(OPC_OPIMM, 0, e_aluwb());
        // jal
        add(OPC_JAL, 1, e_fetch(1)); add(OPC_JAL, 1, e_decode());
        add(OPC_JAL, 1, e_jal());    add(OPC_JAL, 1, e_aluwb());
        // FETCH stalled three cycles, then R-type completes
        add(OPC_OP, 0, e_fetch(0)); add(OPC_OP, 0, e_fetch(0)); add(OPC_OP, 0, e_fetch(0));
        add(OPC_OP, 1, e_fetch(1)); add(OPC_OP, 1, e_decode());
        add(OPC_OP, 1, e_execr());  add(OPC_OP, 1, e_aluwb());

        // Reset entry and release
        #2 iRST = 1'b0;
        @(negedge iCLK);
        check("reset_init", e_init());
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        check("reset_hold", e_init());
        iRST = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].opc, vecs[i].rdy, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a stalled store
        drive(OPC_STORE, 1, e_fetch(1),    "rst_sw_fetch");
        drive(OPC_STORE, 1, e_decode(),    "rst_sw_decode");
        drive(OPC_STORE, 0, e_memadr(),    "rst_sw_memadr");
        drive(OPC_STORE, 0, e_memwrite(),  "rst_sw_memwrite");
        #1 iRST = 1'b0;
        #1 check("rst_async", e_init());
        @(posedge iCLK);
        #1 check("rst_async_edge", e_init());
        @(negedge iCLK);
        iRST = 1'b1;
        @(posedge iCLK);
        #1 check("rst_release", e_fetch(0));

        // Illegal opcode
        drive(OPC_ILL, 1, e_fetch(1), "ill_fetch");
        drive(OPC_ILL, 1, e_decode(), "ill_decode");
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            drive((i % 2 == 0) ? OPC_ILL : OPC_OP, 1'(i % 2), e_halt(), $sformatf("halt_hold%0d", i));
        end
`else
        drive(OPC_ILL, 0, e_fetch(0), "ill_nop_fetch");
        drive(OPC_OP, 1, e_fetch(1), "ill_next_fetch");
        drive(OPC_OP, 1, e_decode(), "ill_next_decode");
        drive(OPC_OP, 1, e_execr(), "ill_next_execr");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
